regfile_wb_sched: RTL and testbench

- Write-port scheduler and scoreboard for the 32-entry integer register file (2 read ports, 1 write port).
- Shares the single write port among NREQ writeback requesters using round-robin arbitration.
- Drives the regfile write strobe, destination address and write data from registered outputs.
- Tracks per-register pending-write busy bits so the issue stage stalls on RAW/WAW hazards until the producer's write lands.

---
 rtl/regfile_wb_sched.sv | 139 +++++++++++++
 tb/tb_regfile_wb_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Write-port scheduler and busy-bit scoreboard for the 32-entry integer register file.
// Optional checker: define WB_SCHED_CHECK_EN to add the sticky err output and the grant assertion.
module regfile_wb_sched #(
  parameter int NREQ = 3,
  parameter int XLEN = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_rs1,
  input  logic [4:0]           iss_rs2,
  input  logic [4:0]           iss_rd,
  input  logic                 iss_wen,
  output logic                 iss_stall,
  input  logic [NREQ-1:0]      wb_valid,
  input  logic [NREQ*5-1:0]    wb_rd,
  input  logic [NREQ*XLEN-1:0] wb_data,
  output logic [NREQ-1:0]      wb_ready,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [31:0]          busy
`ifdef WB_SCHED_CHECK_EN
  ,
  output logic                 err
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: a requester raises wb_valid[i] and holds wb_rd/wb_data stable; the
  // transfer happens in the cycle where wb_valid[i] & wb_ready[i], and only then may
  // the requester change its payload or drop valid. wb_ready never depends on the
  // requester seeing its own grant first.

  logic [PW-1:0]   r_rr_ptr;
  logic [31:0]     r_busy;
  logic            r_we;
  logic [4:0]      r_waddr;
  logic [XLEN-1:0] r_wdata;

  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_gidx;
  logic            w_found;
  logic            w_xfer;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic            w_stall;
  logic            w_alloc;
  logic [31:0]     w_busy_nxt;

  function automatic logic [PW-1:0] wrap_idx(input int v);
    return PW'(v % NREQ);
  endfunction

  // Round-robin search: first valid requester at or after r_rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && wb_valid[wrap_idx(int'(r_rr_ptr) + k)]) begin
        w_found = 1'b1;
        w_gidx  = wrap_idx(int'(r_rr_ptr) + k);
      end
    end
    if (w_found && !rst) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  assign wb_ready   = w_grant;
  assign w_xfer     = w_found & ~rst;
  assign w_sel_rd   = wb_rd[5*int'(w_gidx) +: 5];
  assign w_sel_data = wb_data[XLEN*int'(w_gidx) +: XLEN];

  assign w_stall   = iss_valid & (r_busy[iss_rs1] | r_busy[iss_rs2] | (iss_wen & r_busy[iss_rd]));
  assign iss_stall = w_stall;
  assign w_alloc   = iss_valid & ~w_stall & iss_wen & (iss_rd != 5'd0);

  // The clear tracks the write that is on the regfile port this cycle; a same-edge set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_we) begin
      w_busy_nxt[r_waddr] = 1'b0;
    end
    if (w_alloc) begin
      w_busy_nxt[iss_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_busy   <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_xfer) begin
        r_rr_ptr <= wrap_idx(int'(w_gidx) + 1);
        r_we     <= (w_sel_rd != 5'd0);
        r_waddr  <= w_sel_rd;
        r_wdata  <= w_sel_data;
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign busy     = r_busy;

`ifdef WB_SCHED_CHECK_EN
  logic r_err;
  logic w_err_set;

  // A landing write must match an outstanding allocation; a fresh allocation must not overlap one.
  assign w_err_set = (w_xfer & (w_sel_rd != 5'd0) & ~r_busy[w_sel_rd]) |
                     (w_alloc & r_busy[iss_rd]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(wb_ready));
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: scoreboard allocation/clear, round-robin order,
// rd=0 writebacks, WAW/RAW stalls and asynchronous reset mid-stream.
module tb_regfile_wb_sched;

  localparam int NREQ = 3;
  localparam int XLEN = 64;

  logic                 clk;
  logic                 rst;
  logic                 iss_valid;
  logic [4:0]           iss_rs1;
  logic [4:0]           iss_rs2;
  logic [4:0]           iss_rd;
  logic                 iss_wen;
  logic                 iss_stall;
  logic [NREQ-1:0]      wb_valid;
  logic [NREQ*5-1:0]    wb_rd;
  logic [NREQ*XLEN-1:0] wb_data;
  logic [NREQ-1:0]      wb_ready;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic [31:0]          busy;
`ifdef WB_SCHED_CHECK_EN
  logic                 err;
`endif

  int checks;
  int failures;

  logic [4:0]      cur_rd[NREQ];
  logic [XLEN-1:0] cur_data[NREQ];

  regfile_wb_sched #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .iss_wen   (iss_wen),
    .iss_stall (iss_stall),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy)
`ifdef WB_SCHED_CHECK_EN
    ,
    .err       (err)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic [NREQ-1:0] v);
    wb_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      wb_rd[5*i +: 5]       = cur_rd[i];
      wb_data[XLEN*i +: XLEN] = cur_data[i];
    end
  endtask

  task automatic set_iss(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wen);
    iss_valid = v;
    iss_rs1   = rs1;
    iss_rs2   = rs2;
    iss_rd    = rd;
    iss_wen   = wen;
  endtask

  int          exp_g[6] = '{0, 1, 2, 0, 1, 2};
  logic [4:0]  exp_rd;
  logic [63:0] exp_data;

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < NREQ; i++) begin
      cur_rd[i]   = 5'(i + 1);
      cur_data[i] = 64'(i);
    end
    rst = 1'b1;
    set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    set_wb(3'b111);
    #2;
    chk("rst_wb_ready", 64'(wb_ready), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_rf_we", 64'(rf_we), 64'h0);
    chk("rst_rf_waddr", 64'(rf_waddr), 64'h0);
    chk("rst_rf_wdata", rf_wdata, 64'h0);
    set_wb(3'b000);
    cyc();
    cyc();
    rst = 1'b0;

    // 1: allocate rd=5, RAW stall, requester 1 writes it back
    set_iss(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
    #1;
    chk("t1_alloc_nostall", 64'(iss_stall), 64'h0);
    cyc();
    set_iss(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    cur_rd[1]   = 5'd5;
    cur_data[1] = 64'hDEAD;
    set_wb(3'b010);
    #1;
    chk("t1_busy5", 64'(busy), 64'h20);
    chk("t1_raw_stall", 64'(iss_stall), 64'h1);
    chk("t1_grant1", 64'(wb_ready), 64'h2);
    cyc();
    set_wb(3'b000);
    #1;
    chk("t1_rf_we", 64'(rf_we), 64'h1);
    chk("t1_rf_waddr", 64'(rf_waddr), 64'h5);
    chk("t1_rf_wdata", rf_wdata, 64'hDEAD);
    chk("t1_busy_t1", 64'(busy), 64'h20);
    chk("t1_stall_t1", 64'(iss_stall), 64'h1);
    cyc();
    chk("t1_rf_we_t2", 64'(rf_we), 64'h0);
    chk("t1_busy_t2", 64'(busy), 64'h0);
    chk("t1_stall_t2", 64'(iss_stall), 64'h0);
    chk("t1_waddr_hold", 64'(rf_waddr), 64'h5);
    set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // 4: rd=0 writeback from requester 2 (rr_ptr is 2 after the grant above)
    cur_rd[2]   = 5'd0;
    cur_data[2] = 64'h55;
    set_wb(3'b100);
    #1;
    chk("t4_grant2", 64'(wb_ready), 64'h4);
    cyc();
    set_wb(3'b000);
    #1;
    chk("t4_rf_we", 64'(rf_we), 64'h0);
    chk("t4_busy", 64'(busy), 64'h0);

    // 2: all requesters valid from rr_ptr=0, back-to-back writes
    for (int i = 0; i < NREQ; i++) begin
      cur_rd[i]   = 5'(10 + i);
      cur_data[i] = 64'h100 + 64'(i);
    end
    exp_rd   = '0;
    exp_data = '0;
    for (int n = 0; n < 6; n++) begin
      set_wb(3'b111);
      #1;
      chk("t2_rr_grant", 64'(wb_ready), 64'(3'b001 << exp_g[n]));
      if (n > 0) begin
        chk("t2_rf_we", 64'(rf_we), 64'h1);
        chk("t2_rf_waddr", 64'(rf_waddr), 64'(exp_rd));
        chk("t2_rf_wdata", rf_wdata, exp_data);
      end
      exp_rd   = cur_rd[exp_g[n]];
      exp_data = cur_data[exp_g[n]];
      cyc();
      cur_rd[exp_g[n]]   = cur_rd[exp_g[n]] + 5'd3;
      cur_data[exp_g[n]] = cur_data[exp_g[n]] + 64'h1000;
    end
    set_wb(3'b000);
    #1;
    chk("t2_last_we", 64'(rf_we), 64'h1);
    chk("t2_last_waddr", 64'(rf_waddr), 64'(exp_rd));
    chk("t2_last_wdata", rf_wdata, exp_data);

    // 3: only requester 2 valid with rr_ptr=0, then pointer wraps to 0
    cur_rd[2]   = 5'd20;
    cur_data[2] = 64'h2020;
    set_wb(3'b100);
    #1;
    chk("t3_grant2", 64'(wb_ready), 64'h4);
    cyc();
    set_wb(3'b111);
    #1;
    chk("t3_wrap_grant0", 64'(wb_ready), 64'h1);
    chk("t3_rf_waddr", 64'(rf_waddr), 64'd20);
    chk("t3_rf_wdata", rf_wdata, 64'h2020);
    cyc();
    set_wb(3'b000);

    // 5: WAW stall on rd=7, clear when nothing conflicts
    set_iss(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
    #1;
    chk("t5_alloc_nostall", 64'(iss_stall), 64'h0);
    cyc();
    chk("t5_busy7", 64'(busy), 64'h80);
    chk("t5_waw_stall", 64'(iss_stall), 64'h1);
    set_iss(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    chk("t5_nowen_nostall", 64'(iss_stall), 64'h0);
    set_iss(1'b1, 5'd0, 5'd7, 5'd0, 1'b0);
    #1;
    chk("t5_rs2_stall", 64'(iss_stall), 64'h1);
    set_iss(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
    #1;
    chk("t5_alloc3_nostall", 64'(iss_stall), 64'h0);
    cyc();
    set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // 6: asynchronous reset with busy[3] set and a write on the port
    #1;
    chk("t6_busy_pre", 64'(busy), 64'h88);
    cur_rd[0]   = 5'd9;
    cur_rd[2]   = 5'd3;
    cur_data[2] = 64'h33;
    set_wb(3'b101);
    #1;
    chk("t6_grant2", 64'(wb_ready), 64'h4);
    cyc();
    set_wb(3'b001);
    #1;
    chk("t6_inflight_we", 64'(rf_we), 64'h1);
    chk("t6_inflight_waddr", 64'(rf_waddr), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_rf_we", 64'(rf_we), 64'h0);
    chk("t6_rst_busy", 64'(busy), 64'h0);
    chk("t6_rst_wb_ready", 64'(wb_ready), 64'h0);
    chk("t6_rst_rf_waddr", 64'(rf_waddr), 64'h0);
    chk("t6_rst_rf_wdata", rf_wdata, 64'h0);
    cyc();
    cyc();
    rst = 1'b0;
    set_wb(3'b111);
    #1;
    chk("t6_post_rst_grant0", 64'(wb_ready), 64'h1);
    cyc();
    set_wb(3'b000);
    #1;
    chk("t6_post_rst_waddr", 64'(rf_waddr), 64'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
